// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// Bytes are queued on valid_i/ready_o and shifted out LSB first on tx_o,
// with each bit held for clk_div+1 clock cycles.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [DIV_W-1:0]         clk_div,
  input  logic [7:0]               data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lat;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             bit_end;

  assign fifo_empty = (count == '0);
  assign ready_o    = (count != FULL_LEVEL);
  assign push       = valid_i & ready_o;
  assign bit_end    = (div_cnt == div_lat);
  assign level_o    = count;
  assign busy_o     = (state != IDLE) | (count != '0);
  assign tx_o       = tx_reg;

  // Byte storage; written only when a push is accepted, so no reset is needed.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a pop marks the edge on which a new frame begins.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timing, shifter and registered serial output; the divisor is latched at frame start.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      div_cnt   <= '0;
      div_lat   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr];
      div_lat   <= clk_div;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          tx_reg  <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            tx_reg  <= shift_reg[0];
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_reg <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            tx_reg  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          div_cnt <= '0;
          tx_reg  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the FIFO and the expected serial waveform.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b0;
  logic [DIV_W-1:0] clk_div  = '0;
  logic [7:0]       data_i   = '0;
  logic             valid_i  = 1'b0;
  logic             ready_o;
  logic             tx_o;
  logic             busy_o;
  logic [LW-1:0]    level_o;

  uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clk_div  (clk_div),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .tx_o     (tx_o),
    .busy_o   (busy_o),
    .level_o  (level_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: queued bytes and the per-cycle line values still to be shown.
  logic [7:0] model_q [$];
  bit         line_q  [$];
  bit         in_frame = 1'b0;
  bit         exp_tx   = 1'b1;
  int         dut_peak   = 0;
  int         model_peak = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // One rising edge of the model: start a frame if the line is free, then accept the push.
  task automatic model_edge();
    bit         accept;
    logic [9:0] frame;
    logic [7:0] b;
    int         reps;
    accept = valid_i && (model_q.size() != DEPTH);
    if (line_q.size() == 0 && model_q.size() != 0) begin
      b     = model_q.pop_front();
      frame = {1'b1, b, 1'b0};
      reps  = int'(clk_div) + 1;
      for (int i = 0; i < 10; i++) begin
        for (int r = 0; r < reps; r++) begin
          line_q.push_back(frame[i]);
        end
      end
    end
    if (line_q.size() != 0) begin
      exp_tx   = line_q.pop_front();
      in_frame = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      in_frame = 1'b0;
    end
    if (accept) begin
      model_q.push_back(data_i);
    end
  endtask

  task automatic compare_outputs();
    check_output("tx", {31'd0, tx_o}, {31'd0, exp_tx});
    check_output("level", 32'(level_o), 32'(model_q.size()));
    check_output("ready", {31'd0, ready_o}, {31'd0, (model_q.size() != DEPTH)});
    check_output("busy", {31'd0, busy_o}, {31'd0, (in_frame || model_q.size() != 0)});
    if (int'(level_o) > dut_peak) dut_peak = int'(level_o);
    if (model_q.size() > model_peak) model_peak = model_q.size();
  endtask

  task automatic step_cycle();
    @(posedge wb_clk_i);
    model_edge();
    @(negedge wb_clk_i);
    compare_outputs();
  endtask

  task automatic apply_stimulus(input bit v, input logic [7:0] d, input int div);
    valid_i = v;
    data_i  = d;
    clk_div = DIV_W'(div);
    step_cycle();
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    valid_i = 1'b0;
    while ((line_q.size() != 0 || model_q.size() != 0 || in_frame) && n < limit) begin
      step_cycle();
      n++;
    end
    step_cycle();
    check_output("drain_bound", {31'd0, (n < limit)}, 32'd1);
  endtask

  task automatic apply_reset();
    valid_i  = 1'b0;
    wb_rst_i = 1'b1;
    #1;
    check_output("rst_tx", {31'd0, tx_o}, 32'd1);
    check_output("rst_level", 32'(level_o), 32'd0);
    check_output("rst_ready", {31'd0, ready_o}, 32'd1);
    check_output("rst_busy", {31'd0, busy_o}, 32'd0);
    model_q.delete();
    line_q.delete();
    in_frame = 1'b0;
    exp_tx   = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  // Scenario sequence: reset, directed cases, random traffic, summary.
  initial begin
    int accepted;
    int rejected;
    int model_rejected;
    #2;
    apply_reset();

    // Single byte, 4 cycles per bit
    apply_stimulus(1'b1, 8'hA5, 3);
    run_until_idle(200);

    // Back-to-back bytes at one cycle per bit
    dut_peak = 0;
    model_peak = 0;
    apply_stimulus(1'b1, 8'h00, 0);
    apply_stimulus(1'b1, 8'hFF, 0);
    apply_stimulus(1'b1, 8'h55, 0);
    apply_stimulus(1'b1, 8'h0F, 0);
    run_until_idle(200);
    check_output("b2b_peak", 32'(dut_peak), 32'(model_peak));

    // Overflow: six consecutive offers, five accepted
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (ready_o) accepted++;
      apply_stimulus(1'b1, 8'(8'h10 + i), 100);
    end
    check_output("ovf_accepted", 32'(accepted), 32'd5);
    run_until_idle(12000);

    // Divisor change mid-frame only affects the next frame
    apply_stimulus(1'b1, 8'h3C, 7);
    apply_stimulus(1'b1, 8'hC3, 7);
    repeat (20) apply_stimulus(1'b0, 8'h00, 7);
    clk_div = DIV_W'(1);
    run_until_idle(400);

    // Reset during data bit 3 with two bytes queued
    apply_stimulus(1'b1, 8'h81, 3);
    apply_stimulus(1'b1, 8'h42, 3);
    apply_stimulus(1'b1, 8'h24, 3);
    repeat (16) apply_stimulus(1'b0, 8'h00, 3);
    check_output("pre_rst_level", 32'(level_o), 32'd2);
    apply_reset();
    repeat (40) apply_stimulus(1'b0, 8'h00, 3);
    apply_stimulus(1'b1, 8'h5A, 3);
    run_until_idle(200);

    // Keep the FIFO full across frame boundaries with valid held high
    rejected = 0;
    model_rejected = 0;
    for (int i = 0; i < 80; i++) begin
      if (!ready_o) rejected++;
      if (model_q.size() == DEPTH) model_rejected++;
      apply_stimulus(1'b1, 8'($urandom_range(0, 255)), 1);
    end
    check_output("full_rejects", 32'(rejected), 32'(model_rejected));
    run_until_idle(400);

    // Random traffic with a changing divisor and one reset in the middle
    for (int i = 0; i < 500; i++) begin
      if (i == 250) apply_reset();
      apply_stimulus(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                     int'($urandom_range(0, 3)));
    end
    run_until_idle(2000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
